// File: rtl/scalar_mult_sequencer.sv
// Left-to-right double-and-add sequencer computing Q = k*P through an external point adder/doubler.
// Optional macro SCALAR_MULT_CONST_TIME_EN: zero k bits still issue a (discarded) addition request.
module scalar_mult_sequencer #(
    parameter int N  = 231,
    parameter int KW = 231
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          start_i,
    input  logic [KW-1:0] k_i,
    input  logic [N-1:0]  px_i,
    input  logic [N-1:0]  py_i,
    input  logic [N-1:0]  p_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [N-1:0]  qx_o,
    output logic [N-1:0]  qy_o,
    output logic          q_inf_o,
    output logic          op_req_o,
    output logic          op_dbl_o,
    output logic [N-1:0]  op_x1_o,
    output logic [N-1:0]  op_y1_o,
    output logic [N-1:0]  op_x2_o,
    output logic [N-1:0]  op_y2_o,
    output logic [N-1:0]  op_p_o,
    input  logic          op_ack_i,
    input  logic [N-1:0]  op_x3_i,
    input  logic [N-1:0]  op_y3_i,
    input  logic          op_inf_i,
    output logic [2:0]    dbg_state_o
);
    localparam int IW = (KW > 1) ? $clog2(KW) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DBL   = 3'd1,
        S_DBL_W = 3'd2,
        S_ADD   = 3'd3,
        S_ADD_W = 3'd4,
        S_NEXT  = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    // Handshake: op_req_q rises with the operands registered alongside it and
    // stays high until a cycle with op_ack_i; that cycle also carries the result.
    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [N-1:0]    px_q, px_d, py_q, py_d, p_q, p_d;
    logic [N-1:0]    ax_q, ax_d, ay_q, ay_d;
    logic            ainf_q, ainf_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            discard_q, discard_d;
    logic            op_req_q, op_req_d, op_dbl_q, op_dbl_d;
    logic [N-1:0]    op_x1_q, op_x1_d, op_y1_q, op_y1_d;
    logic [N-1:0]    op_x2_q, op_x2_d, op_y2_q, op_y2_d;
    logic            done_q, done_d;
    logic [N-1:0]    qx_q, qx_d, qy_q, qy_d;
    logic            qinf_q, qinf_d;
    logic            issue_dbl, issue_add;
    logic            x_eq, y_eq, ack;

    assign x_eq = (ax_q == px_q);
    assign y_eq = (ay_q == py_q);
    assign ack  = op_ack_i && op_req_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            px_q      <= '0;
            py_q      <= '0;
            p_q       <= '0;
            ax_q      <= '0;
            ay_q      <= '0;
            ainf_q    <= 1'b1;
            idx_q     <= IW'(KW - 1);
            discard_q <= 1'b0;
            op_req_q  <= 1'b0;
            op_dbl_q  <= 1'b0;
            op_x1_q   <= '0;
            op_y1_q   <= '0;
            op_x2_q   <= '0;
            op_y2_q   <= '0;
            done_q    <= 1'b0;
            qx_q      <= '0;
            qy_q      <= '0;
            qinf_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            px_q      <= px_d;
            py_q      <= py_d;
            p_q       <= p_d;
            ax_q      <= ax_d;
            ay_q      <= ay_d;
            ainf_q    <= ainf_d;
            idx_q     <= idx_d;
            discard_q <= discard_d;
            op_req_q  <= op_req_d;
            op_dbl_q  <= op_dbl_d;
            op_x1_q   <= op_x1_d;
            op_y1_q   <= op_y1_d;
            op_x2_q   <= op_x2_d;
            op_y2_q   <= op_y2_d;
            done_q    <= done_d;
            qx_q      <= qx_d;
            qy_q      <= qy_d;
            qinf_q    <= qinf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        px_d      = px_q;
        py_d      = py_q;
        p_d       = p_q;
        ax_d      = ax_q;
        ay_d      = ay_q;
        ainf_d    = ainf_q;
        idx_d     = idx_q;
        discard_d = discard_q;
        op_req_d  = op_req_q;
        op_dbl_d  = op_dbl_q;
        op_x1_d   = op_x1_q;
        op_y1_d   = op_y1_q;
        op_x2_d   = op_x2_q;
        op_y2_d   = op_y2_q;
        done_d    = 1'b0;
        qx_d      = qx_q;
        qy_d      = qy_q;
        qinf_d    = qinf_q;
        issue_dbl = 1'b0;
        issue_add = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    k_d     = k_i;
                    px_d    = px_i;
                    py_d    = py_i;
                    p_d     = p_i;
                    ax_d    = '0;
                    ay_d    = '0;
                    ainf_d  = 1'b1;
                    idx_d   = IW'(KW - 1);
                    state_d = S_DBL;
                end
            end
            S_DBL: begin
                if (ainf_q) begin
                    state_d = S_ADD;
                end else begin
                    op_req_d  = 1'b1;
                    op_dbl_d  = 1'b1;
                    op_x1_d   = ax_q;
                    op_y1_d   = ay_q;
                    op_x2_d   = '0;
                    op_y2_d   = '0;
                    discard_d = 1'b0;
                    state_d   = S_DBL_W;
                end
            end
            S_DBL_W: begin
                if (ack) begin
                    ax_d     = op_x3_i;
                    ay_d     = op_y3_i;
                    ainf_d   = op_inf_i;
                    op_req_d = 1'b0;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                state_d = S_NEXT;
                // The adder cannot take A = P (needs doubling) or A = -P (result is infinity).
                if (k_q[idx_q]) begin
                    discard_d = 1'b0;
                    if (ainf_q) begin
                        ax_d   = px_q;
                        ay_d   = py_q;
                        ainf_d = 1'b0;
                    end else if (x_eq && y_eq) begin
                        issue_dbl = 1'b1;
                    end else if (x_eq) begin
                        ax_d   = '0;
                        ay_d   = '0;
                        ainf_d = 1'b1;
                    end else begin
                        issue_add = 1'b1;
                    end
                end
`ifdef SCALAR_MULT_CONST_TIME_EN
                else if (!ainf_q) begin
                    discard_d = 1'b1;
                    if (x_eq && y_eq) begin
                        issue_dbl = 1'b1;
                    end else if (!x_eq) begin
                        issue_add = 1'b1;
                    end
                end
`endif
            end
            S_ADD_W: begin
                if (ack) begin
                    if (!discard_q) begin
                        ax_d   = op_x3_i;
                        ay_d   = op_y3_i;
                        ainf_d = op_inf_i;
                    end
                    op_req_d = 1'b0;
                    state_d  = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == '0) begin
                    qx_d    = ainf_q ? '0 : ax_q;
                    qy_d    = ainf_q ? '0 : ay_q;
                    qinf_d  = ainf_q;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = S_DBL;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue_dbl) begin
            op_req_d = 1'b1;
            op_dbl_d = 1'b1;
            op_x1_d  = px_q;
            op_y1_d  = py_q;
            op_x2_d  = '0;
            op_y2_d  = '0;
            state_d  = S_ADD_W;
        end
        if (issue_add) begin
            op_req_d = 1'b1;
            op_dbl_d = 1'b0;
            op_x1_d  = ax_q;
            op_y1_d  = ay_q;
            op_x2_d  = px_q;
            op_y2_d  = py_q;
            state_d  = S_ADD_W;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign qx_o        = qx_q;
    assign qy_o        = qy_q;
    assign q_inf_o     = qinf_q;
    assign op_req_o    = op_req_q;
    assign op_dbl_o    = op_dbl_q;
    assign op_x1_o     = op_x1_q;
    assign op_y1_o     = op_y1_q;
    assign op_x2_o     = op_x2_q;
    assign op_y2_o     = op_y2_q;
    assign op_p_o      = p_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_scalar_mult_sequencer.sv
// Directed bench for scalar_mult_sequencer on y^2 = x^3+2x+2 over GF(17), P = (5,1), order 19.
module tb_scalar_mult_sequencer;
    localparam int N  = 8;
    localparam int KW = 8;
    localparam int RW = 4 * N + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k = '0;
    logic [N-1:0]  px = 8'd5, py = 8'd1, p = 8'd17;
    logic          busy, done, q_inf, op_req, op_dbl;
    logic [N-1:0]  qx, qy, op_x1, op_y1, op_x2, op_y2, op_p;
    logic          m_ack = 1'b0, s_ack = 1'b0, op_ack;
    logic [N-1:0]  op_x3 = '0, op_y3 = '0;
    logic          op_inf = 1'b0;
    logic [2:0]    dbg_state;
    logic          model_en = 1'b1;

    int n_vec = 0;
    int n_mis = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] obs_q[$];

    assign op_ack = m_ack | s_ack;

    scalar_mult_sequencer #(.N(N), .KW(KW)) dut (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start), .k_i(k),
        .px_i(px), .py_i(py), .p_i(p),
        .busy_o(busy), .done_o(done), .qx_o(qx), .qy_o(qy), .q_inf_o(q_inf),
        .op_req_o(op_req), .op_dbl_o(op_dbl),
        .op_x1_o(op_x1), .op_y1_o(op_y1), .op_x2_o(op_x2), .op_y2_o(op_y2),
        .op_p_o(op_p), .op_ack_i(op_ack), .op_x3_i(op_x3), .op_y3_i(op_y3),
        .op_inf_i(op_inf), .dbg_state_o(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int md(input int a, input int m);
        int r;
        r = a % m;
        if (r < 0) r += m;
        return r;
    endfunction

    function automatic int inv(input int a, input int m);
        for (int i = 1; i < m; i++) if (md(a * i, m) == 1) return i;
        return 0;
    endfunction

    // behavioural point adder/doubler, a = 2, ack in the third cycle of a request
    initial begin : adder_model
        int x1, y1, x2, y2, pp, lam, x3, y3;
        bit inf3, dbl;
        forever begin
            @(posedge clk); #1;
            if (model_en && reset_n && op_req) begin
                x1 = int'(op_x1); y1 = int'(op_y1); x2 = int'(op_x2); y2 = int'(op_y2);
                pp = int'(op_p); dbl = op_dbl;
                obs_q.push_back(op_dbl ? {1'b1, op_x1, op_y1, 16'h0} : {1'b0, op_x1, op_y1, op_x2, op_y2});
                if (!dbl && x1 == x2 && y1 == y2) dbl = 1'b1;
                inf3 = 1'b0; lam = 0;
                if (dbl) begin
                    if (y1 == 0) inf3 = 1'b1;
                    else lam = md((3 * x1 * x1 + 2) * inv(md(2 * y1, pp), pp), pp);
                    x2 = x1;
                end else begin
                    if (x1 == x2) inf3 = 1'b1;
                    else lam = md(md(y2 - y1, pp) * inv(md(x2 - x1, pp), pp), pp);
                end
                x3 = md(lam * lam - x1 - x2, pp);
                y3 = md(lam * (x1 - x3) - y1, pp);
                repeat (2) begin @(posedge clk); #1; end
                m_ack  = 1'b1;
                op_x3  = inf3 ? '0 : N'(x3);
                op_y3  = inf3 ? '0 : N'(y3);
                op_inf = inf3;
                @(posedge clk); #1;
                m_ack = 1'b0;
            end
        end
    end

    task automatic cmp_reqs(input string tag);
        logic [RW-1:0] e;
        chk({tag, ".nreq"}, RW'(obs_q.size()), RW'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) chk({tag, ".req"}, obs_q.pop_front(), e);
            else chk({tag, ".req_missing"}, '0, e);
        end
        obs_q.delete();
    endtask

    task automatic run_k(input string tag, input logic [KW-1:0] kv, input logic [N-1:0] ex,
                         input logic [N-1:0] ey, input logic einf, input int elat, input bit poke);
        int cyc;
        obs_q.delete();
        @(posedge clk); #1;
        start = 1'b1; k = kv;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        chk({tag, ".busy"}, RW'(busy), RW'(1));
        while (!done && cyc < 2000) begin
            if (poke && cyc == 6) begin start = 1'b1; k = 8'h01; px = 8'd3; end
            @(posedge clk); #1;
            start = 1'b0; px = 8'd5;
            cyc++;
        end
        chk({tag, ".done_seen"}, RW'(done), RW'(1));
        if (elat > 0) chk({tag, ".latency"}, RW'(cyc), RW'(elat));
        chk({tag, ".qx"}, RW'(qx), RW'(ex));
        chk({tag, ".qy"}, RW'(qy), RW'(ey));
        chk({tag, ".q_inf"}, RW'(q_inf), RW'(einf));
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, RW'(done), RW'(0));
        chk({tag, ".busy_end"}, RW'(busy), RW'(0));
        chk({tag, ".held_qx"}, RW'(qx), RW'(ex));
    endtask

    initial begin : main
        int w;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", RW'(busy), RW'(0));
        chk("rst.done", RW'(done), RW'(0));
        chk("rst.op_req", RW'(op_req), RW'(0));
        chk("rst.op_dbl", RW'(op_dbl), RW'(0));
        chk("rst.q_inf", RW'(q_inf), RW'(1));
        chk("rst.qx", RW'(qx), RW'(0));
        chk("rst.op_x1", RW'(op_x1), RW'(0));
        chk("rst.state", RW'(dbg_state), RW'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // 1P: no requests
        run_k("k1", 8'd1, 8'd5, 8'd1, 1'b0, 0, 1'b0);
        cmp_reqs("k1");

        // 2P = (6,3): one doubling of (5,1)
        exp_q.push_back({1'b1, 8'd5, 8'd1, 16'h0});
        run_k("k2", 8'd2, 8'd6, 8'd3, 1'b0, 0, 1'b0);
        cmp_reqs("k2");

        // 9P = (7,6): dbl P, dbl 2P, dbl 4P, add 8P+P; a start pulse mid-run must be ignored
        exp_q.push_back({1'b1, 8'd5, 8'd1, 16'h0});
        exp_q.push_back({1'b1, 8'd6, 8'd3, 16'h0});
        exp_q.push_back({1'b1, 8'd3, 8'd1, 16'h0});
        exp_q.push_back({1'b0, 8'd13, 8'd7, 8'd5, 8'd1});
        run_k("k9", 8'd9, 8'd7, 8'd6, 1'b0, 0, 1'b1);
        cmp_reqs("k9");

        // 19P = O: 18P = (5,16) = -P, final addition resolved locally
        exp_q.push_back({1'b1, 8'd5, 8'd1, 16'h0});
        exp_q.push_back({1'b1, 8'd6, 8'd3, 16'h0});
        exp_q.push_back({1'b1, 8'd3, 8'd1, 16'h0});
        exp_q.push_back({1'b0, 8'd13, 8'd7, 8'd5, 8'd1});
        exp_q.push_back({1'b1, 8'd7, 8'd6, 16'h0});
        run_k("k19", 8'd19, 8'd0, 8'd0, 1'b1, 0, 1'b0);
        cmp_reqs("k19");

        // k = 0: done in cycle 3*KW+1 counting the first DBL cycle as cycle 1
        run_k("k0", 8'd0, 8'd0, 8'd0, 1'b1, 3 * KW + 1, 1'b0);
        cmp_reqs("k0");

        // reset while waiting for a doubling ack, then a stray ack
        model_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; k = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!op_req && w < 200) begin @(posedge clk); #1; w++; end
        chk("abort.req_seen", RW'(op_req), RW'(1));
        chk("abort.state_dblw", RW'(dbg_state), RW'(2));
        reset_n = 1'b0;
        #1;
        chk("abort.busy", RW'(busy), RW'(0));
        chk("abort.op_req", RW'(op_req), RW'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        s_ack = 1'b1; op_x3 = 8'd9; op_y3 = 8'd9; op_inf = 1'b0;
        @(posedge clk); #1;
        s_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("stray.busy", RW'(busy), RW'(0));
        chk("stray.op_req", RW'(op_req), RW'(0));
        chk("stray.done", RW'(done), RW'(0));
        chk("stray.q_inf", RW'(q_inf), RW'(1));
        chk("stray.qx", RW'(qx), RW'(0));
        obs_q.delete();
        model_en = 1'b1;

        exp_q.push_back({1'b1, 8'd5, 8'd1, 16'h0});
        run_k("k2b", 8'd2, 8'd6, 8'd3, 1'b0, 0, 1'b0);
        cmp_reqs("k2b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/scalar_mult_sequencer.md
Name: scalar_mult_sequencer

Overview:
- Initiator side of the point-arithmetic operand/result protocol.
- Computes Q = k·P by left-to-right double-and-add.
- Issues doubling and addition requests to an external point adder/doubler and collects its results.
- Sits between the ECC top-level control and the point arithmetic units.
- Screens out the cases the adder cannot handle (Q or P at infinity, Q == P, Q == −P) and resolves them locally.

Parameters:
- n, 231, field element width in bits.
- KW, 231, scalar width in bits.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches k, px, py, p. Ignored while busy.
- k  in  KW  scalar.
- px, py  in  n  base point P, both coordinates < p.
- p  in  n  field prime.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the result is valid.
- qx, qy  out  n  result; held until the next start.
- q_inf  out  1  result is the point at infinity.
- op_req  out  1  request to the adder; held until op_ack.
- op_dbl  out  1  1 = doubling (x1,y1), 0 = addition (x1,y1)+(x2,y2).
- op_x1, op_y1, op_x2, op_y2  out  n  operands; stable while op_req is high.
- op_p  out  n  prime forwarded to the adder.
- op_ack  in  1  one-cycle pulse; result valid in the same cycle.
- op_x3, op_y3  in  n  adder result.
- op_inf  in  1  adder result is infinity.

Behaviour:
- Reset (async, active-low): state IDLE; busy, done, op_req, op_dbl = 0; qx, qy, op_* = 0; q_inf = 1; bit index = KW−1.
- States: IDLE, DBL, DBL_W, ADD, ADD_W, NEXT, FIN.
- IDLE:
  - On start: latch k, P, p; accumulator A = infinity; index i = KW−1; go to DBL.
- DBL:
  - If A is infinity: go to ADD with no request (1 cycle).
  - Else: op_req = 1, op_dbl = 1, x1/y1 = A; go to DBL_W.
- DBL_W:
  - Wait for op_ack. On ack: A = (op_x3, op_y3, op_inf); op_req = 0 in the next cycle; go to ADD.
- ADD, when k[i] = 0: go to NEXT.
- ADD, when k[i] = 1:
  - A infinity → A = P, no request.
  - A.x == px and A.y == py → doubling request of P.
  - A.x == px and A.y != py → A = infinity, no request.
  - Otherwise → op_dbl = 0, x1/y1 = A, x2/y2 = P; go to ADD_W.
- ADD_W: same as DBL_W; on ack go to NEXT.
- NEXT:
  - If i == 0: go to FIN.
  - Else: i−1, go to DBL.
- FIN:
  - qx, qy, q_inf = A; done = 1 for this cycle only; busy = 0 from the next cycle; go to IDLE.
  - When q_inf = 1, qx and qy = 0.
- Timing:
  - Skipped bit (no request) costs 3 cycles: DBL, ADD, NEXT.
  - Each request adds its ack latency plus 1.
  - k = 0 → done in cycle 3·KW+1 after the start edge.
- Handshake:
  - op_req never drops before op_ack.
  - op_ack while op_req = 0 is ignored.
  - At most one outstanding request.
- start while busy: ignored; latched operands unchanged.
- Reset mid-operation: immediate abort to reset values; a later op_ack is ignored.
- No arithmetic is performed locally; only equality compares on n-bit values.

Optional Feature:
- Macro: SCALAR_MULT_CONST_TIME_EN.
- Defined:
  - When k[i] = 0 and A is not infinity, ADD still issues an addition request A+P (or the equivalent doubling/skip per the special-case rules).
  - The result is discarded; A is unchanged.
  - The request pattern is independent of the k bit values once A is non-infinity.
- Undefined: bits equal to 0 issue no addition request (behaviour as above).

Test Plan:
- Bench setup: n = 8, KW = 8, p = 17, curve y² = x³+2x+2, P = (5,1); behavioural adder model with a 3-cycle ack.
- k = 1 → qx = 5, qy = 1, q_inf = 0; zero op_req pulses.
- k = 2 → (6,3); exactly one doubling request, with operands (5,1).
- k = 9 → (7,6); request sequence: dbl, dbl, dbl, add.
- k = 19 → q_inf = 1, qx = qy = 0; the final addition hits the Q == −P case, resolved locally.
- k = 0 → q_inf = 1; no requests; done exactly 25 cycles after start.
- Robustness:
  - start pulsed while busy → ignored.
  - Reset asserted in DBL_W → busy = 0, op_req = 0 immediately; stray op_ack ignored.
  - A new k = 2 run afterwards → (6,3).
